cpu_run_monitor: RTL and testbench
==================================

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 Parameter DATA_W, default 32: width of ALU result and signature.
REQ-002 Parameter PC_W, default 32: width of program counter.
REQ-003 Parameter TRACE_DEPTH, default 8: PC trace entries, power of two, >= 2.
REQ-004 Parameter RST_HOLD, default 2: cycles cpu_rst stays high after monitor reset release, >= 1.
REQ-005 Parameter WDOG_MAX, default 1024: consecutive unchanged-PC RUN cycles before timeout.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset (low = reset).
REQ-008 halt  input  1  CPU halt indication.
REQ-009 Alures  input  DATA_W  CPU ALU result.
REQ-010 pc  input  PC_W  CPU program counter.
REQ-011 clear  input  1  synchronous restart pulse.
REQ-012 bp_en, bp_addr  input  1, PC_W  breakpoint enable and address.
REQ-013 resume  input  1  leave BREAK state.
REQ-014 trace_idx  input  log2(TRACE_DEPTH)  trace read index, 0 = newest.
REQ-015 cpu_rst  output  1  active-high reset to CPU.
REQ-016 cpu_stall  output  1  stall request to CPU.
REQ-017 state  output  3  encoded FSM state.
REQ-018 cycles  output  32  RUN cycle count.
REQ-019 signature  output  DATA_W  ALU result signature.
REQ-020 trace_pc, trace_cnt  output  PC_W, log2(TRACE_DEPTH)+1  trace read data, valid entries.

Function
REQ-021 FSM states SHALL be HOLD=0, RUN=1, HALTED=2, TIMEOUT=3, BREAK=4.
REQ-022 HOLD: cpu_rst=1, hold counter increments; after exactly RST_HOLD cycles -> RUN.
REQ-023 RUN: cpu_rst=0, cycles increments by 1 per cycle, saturating at 2^32-1.
REQ-024 RUN: signature <= {signature rotated left by 1} XOR Alures each cycle.
REQ-025 RUN: when pc differs from previous-cycle pc, pc SHALL be written to trace at write pointer; pointer wraps modulo TRACE_DEPTH; trace_cnt saturates at TRACE_DEPTH.
REQ-026 trace_pc SHALL combinationally return entry (newest - trace_idx); indices >= trace_cnt return 0.
REQ-027 Watchdog counter increments in RUN while pc unchanged, clears on change; on reaching WDOG_MAX -> TIMEOUT.
REQ-028 bp_en=1 and pc==bp_addr in RUN -> BREAK; cpu_stall=1 only in BREAK; resume in BREAK -> RUN, watchdog cleared.
REQ-029 halt=1 in RUN or BREAK -> HALTED; HALTED and TIMEOUT are terminal until clear or reset.
REQ-030 Priority on same cycle: clear > halt > watchdog timeout > breakpoint.
REQ-031 clear in any state -> HOLD next cycle; cycles, signature, watchdog, trace_cnt, write pointer zeroed.
REQ-032 cycles, signature, trace SHALL freeze outside RUN.

Reset
REQ-033 rst low SHALL asynchronously force state=HOLD, cpu_rst=1, cpu_stall=0, cycles=0, signature=0, trace_cnt=0, pointers and counters 0; trace storage need not clear.
REQ-034 rst asserted mid-RUN SHALL abort immediately; release restarts full RST_HOLD sequence.

Configuration
REQ-035 Macro RUN_MON_TRACE_EN defined: trace buffer per REQ-025/026 present.
REQ-036 Macro undefined: no trace storage; trace_pc=0, trace_cnt=0 constantly; all other behaviour unchanged.

Structure
REQ-037 Package cpu_mon_pkg SHALL hold the state enum/encodings and signature width-independent constants.
REQ-038 Sub-module cpu_mon_trace (circular PC buffer, write pointer, count, read mux) SHALL be instantiated only under RUN_MON_TRACE_EN.

Verification
REQ-039 rst low 3 cycles then high, RST_HOLD=2 -> cpu_rst high exactly 2 cycles after release, state=1 on third.
REQ-040 pc increments by 4 from 0x0 for 10 cycles, TRACE_DEPTH=8 -> trace_cnt=8, trace_idx=0 gives 0x24, trace_idx=7 gives 0x8.
REQ-041 pc held at 0x40, WDOG_MAX=16 -> state=3 after 16 RUN cycles; cycles frozen thereafter.
REQ-042 bp_en=1, bp_addr=0x10, pc reaches 0x10 -> state=4, cpu_stall=1; resume pulse -> state=1, cpu_stall=0.
REQ-043 Alures=0x1 then 0x2 from signature 0 -> signature 0x1 then 0x0; halt and bp match same cycle -> state=2.
REQ-044 clear asserted in TIMEOUT -> state=0, cycles=0, signature=0, trace_cnt=0 next cycle.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// cpu_mon_pkg: shared FSM state encoding and width-independent constants
// for the CPU run monitor.
package cpu_mon_pkg;

  localparam int STATE_W  = 3;
  localparam int CYCLES_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_HALTED  = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_BREAK   = 3'd4
  } mon_state_e;

  localparam logic [CYCLES_W-1:0] CYCLES_MAX = 32'hFFFF_FFFF;
  localparam logic [CYCLES_W-1:0] CYCLES_ONE = 32'h0000_0001;

endpackage

// File: rtl/cpu_mon_trace.sv
// cpu_mon_trace: circular buffer of PC values captured on PC change.
// Entry 0 of the read port is the newest write; indices at or beyond the
// number of valid entries read as zero. Storage itself is not reset.
module cpu_mon_trace
  import cpu_mon_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic [AW-1:0]   rd_idx,
  output logic [PC_W-1:0] rd_pc,
  output logic [AW:0]     cnt
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]   wptr_r;
  logic [AW:0]     cnt_r;
  logic [AW-1:0]   rd_addr_s;

  // Write pointer wraps naturally; count saturates at the buffer depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_r <= '0;
      cnt_r  <= '0;
    end else if (clear) begin
      wptr_r <= '0;
      cnt_r  <= '0;
    end else if (wr_en) begin
      wptr_r <= wptr_r + AW'(1);
      cnt_r  <= (cnt_r == CNT_FULL) ? cnt_r : cnt_r + (AW+1)'(1);
    end else begin
      wptr_r <= wptr_r;
      cnt_r  <= cnt_r;
    end
  end

  // Trace storage: plain RAM-style write, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem_r[wptr_r] <= wr_pc;
    end
  end

  // Newest-relative read: newest entry sits one below the write pointer.
  always_comb begin
    rd_addr_s = wptr_r - AW'(1) - rd_idx;
    if ({1'b0, rd_idx} < cnt_r) begin
      rd_pc = mem_r[rd_addr_s];
    end else begin
      rd_pc = '0;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: holds the CPU in reset for RST_HOLD cycles, then tracks
// run cycles, an ALU result signature, a PC watchdog and a breakpoint.
// Optional PC trace buffer is built only when RUN_MON_TRACE_EN is defined;
// otherwise trace_pc and trace_cnt are tied to zero.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 8,
  parameter int RST_HOLD    = 2,
  parameter int WDOG_MAX    = 1024,
  localparam int TRACE_AW   = $clog2(TRACE_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt,
  input  logic [DATA_W-1:0]   Alures,
  input  logic [PC_W-1:0]     pc,
  input  logic                clear,
  input  logic                bp_en,
  input  logic [PC_W-1:0]     bp_addr,
  input  logic                resume,
  input  logic [TRACE_AW-1:0] trace_idx,
  output logic                cpu_rst,
  output logic                cpu_stall,
  output logic [2:0]          state,
  output logic [31:0]         cycles,
  output logic [DATA_W-1:0]   signature,
  output logic [PC_W-1:0]     trace_pc,
  output logic [TRACE_AW:0]   trace_cnt
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int WDOG_W = $clog2(WDOG_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

  // Signature step: rotate left by one, then fold in the ALU result.
  function automatic logic [DATA_W-1:0] sig_step(input logic [DATA_W-1:0] sig,
                                                 input logic [DATA_W-1:0] alu);
    return {sig[DATA_W-2:0], sig[DATA_W-1]} ^ alu;
  endfunction

  mon_state_e            state_r, state_nxt_s;
  logic [HOLD_W-1:0]     hold_cnt_r;
  logic [WDOG_W-1:0]     wdog_cnt_r;
  logic [PC_W-1:0]       prev_pc_r;
  logic [CYCLES_W-1:0]   cycles_r;
  logic [DATA_W-1:0]     sig_r;
  logic                  cpu_rst_r, cpu_stall_r;
  logic                  in_run_s, pc_same_s, hold_done_s, wdog_hit_s, bp_hit_s;

  assign in_run_s    = (state_r == ST_RUN);
  assign pc_same_s   = (pc == prev_pc_r);
  assign hold_done_s = (hold_cnt_r == HOLD_LAST);
  assign wdog_hit_s  = pc_same_s && (wdog_cnt_r == WDOG_LAST);
  assign bp_hit_s    = bp_en && (pc == bp_addr);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: clear > halt > watchdog timeout > breakpoint.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = ST_HOLD;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (hold_done_s) state_nxt_s = ST_RUN;
          else             state_nxt_s = ST_HOLD;
        end
        ST_RUN: begin
          if (halt)            state_nxt_s = ST_HALTED;
          else if (wdog_hit_s) state_nxt_s = ST_TIMEOUT;
          else if (bp_hit_s)   state_nxt_s = ST_BREAK;
          else                 state_nxt_s = ST_RUN;
        end
        ST_BREAK: begin
          if (halt)        state_nxt_s = ST_HALTED;
          else if (resume) state_nxt_s = ST_RUN;
          else             state_nxt_s = ST_BREAK;
        end
        ST_HALTED:  state_nxt_s = ST_HALTED;
        ST_TIMEOUT: state_nxt_s = ST_TIMEOUT;
        default:    state_nxt_s = ST_HOLD;
      endcase
    end
  end

  // CPU reset and stall are registered from the next state so they track it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rst_r   <= 1'b1;
      cpu_stall_r <= 1'b0;
    end else begin
      cpu_rst_r   <= (state_nxt_s == ST_HOLD);
      cpu_stall_r <= (state_nxt_s == ST_BREAK);
    end
  end

  // Hold counter times the CPU reset window; restarts on every entry to HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_r <= '0;
    end else if (clear) begin
      hold_cnt_r <= '0;
    end else if (state_r == ST_HOLD) begin
      hold_cnt_r <= hold_done_s ? '0 : hold_cnt_r + HOLD_W'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Previous-cycle PC, sampled every cycle for change detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc_r <= '0;
    end else begin
      prev_pc_r <= pc;
    end
  end

  // Watchdog counts unchanged-PC RUN cycles; a resume from BREAK rearms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_r <= '0;
    end else if (clear) begin
      wdog_cnt_r <= '0;
    end else if (in_run_s) begin
      wdog_cnt_r <= pc_same_s ? wdog_cnt_r + WDOG_W'(1) : '0;
    end else if ((state_r == ST_BREAK) && resume) begin
      wdog_cnt_r <= '0;
    end else begin
      wdog_cnt_r <= wdog_cnt_r;
    end
  end

  // Run-cycle counter (saturating) and signature advance only in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_r <= '0;
      sig_r    <= '0;
    end else if (clear) begin
      cycles_r <= '0;
      sig_r    <= '0;
    end else if (in_run_s) begin
      cycles_r <= (cycles_r == CYCLES_MAX) ? cycles_r : cycles_r + CYCLES_ONE;
      sig_r    <= sig_step(sig_r, Alures);
    end else begin
      cycles_r <= cycles_r;
      sig_r    <= sig_r;
    end
  end

  assign cpu_rst   = cpu_rst_r;
  assign cpu_stall = cpu_stall_r;
  assign state     = state_r;
  assign cycles    = cycles_r;
  assign signature = sig_r;

`ifdef RUN_MON_TRACE_EN
  cpu_mon_trace #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .wr_en  (in_run_s && !pc_same_s),
    .wr_pc  (pc),
    .rd_idx (trace_idx),
    .rd_pc  (trace_pc),
    .cnt    (trace_cnt)
  );
`else
  logic unused_trace_idx_s;
  assign unused_trace_idx_s = ^trace_idx;
  assign trace_pc  = '0;
  assign trace_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor (RST_HOLD=2, WDOG_MAX=16, TRACE_DEPTH=8).
// Trace content checks apply when RUN_MON_TRACE_EN is defined; otherwise the
// trace outputs are checked to stay zero.
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [31:0] alures;
  logic [31:0] pc;
  logic        clear;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        resume;
  logic [2:0]  trace_idx;
  logic        cpu_rst;
  logic        cpu_stall;
  logic [2:0]  state;
  logic [31:0] cycles;
  logic [31:0] signature;
  logic [31:0] trace_pc;
  logic [3:0]  trace_cnt;

  int n_vec = 0;
  int n_err = 0;

  cpu_run_monitor #(
    .DATA_W      (32),
    .PC_W        (32),
    .TRACE_DEPTH (8),
    .RST_HOLD    (2),
    .WDOG_MAX    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .Alures    (alures),
    .pc        (pc),
    .clear     (clear),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .resume    (resume),
    .trace_idx (trace_idx),
    .cpu_rst   (cpu_rst),
    .cpu_stall (cpu_stall),
    .state     (state),
    .cycles    (cycles),
    .signature (signature),
    .trace_pc  (trace_pc),
    .trace_cnt (trace_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0; halt = 1'b0; alures = 32'h0; pc = 32'h0; clear = 1'b0;
    bp_en = 1'b0; bp_addr = 32'h0; resume = 1'b0; trace_idx = 3'd0;

    // Reset held low for three cycles.
    repeat (3) step();
    chk("rst_state", state, 3'd0);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_sig", signature, 32'd0);
    chk("rst_tcnt", trace_cnt, 4'd0);
    rst = 1'b1;
    step();
    chk("hold1_state", state, 3'd0);
    chk("hold1_cpu_rst", cpu_rst, 1'b1);
    step();
    chk("run_state", state, 3'd1);
    chk("run_cpu_rst", cpu_rst, 1'b0);
    chk("run_cycles0", cycles, 32'd0);

    // Signature: 0x1 then 0x2 from zero.
    alures = 32'h1; pc = 32'h4;
    step();
    chk("sig_a", signature, 32'h1);
    chk("cycles_1", cycles, 32'd1);
    alures = 32'h2; pc = 32'h8;
    step();
    chk("sig_b", signature, 32'h0);
    alures = 32'h0;
    for (int k = 3; k <= 9; k++) begin
      pc = 32'(4 * k);
      step();
    end
    chk("cycles_9", cycles, 32'd9);
`ifdef RUN_MON_TRACE_EN
    chk("trace_cnt_full", trace_cnt, 4'd8);
    trace_idx = 3'd0; #1;
    chk("trace_idx0", trace_pc, 32'h24);
    trace_idx = 3'd2; #1;
    chk("trace_idx2", trace_pc, 32'h1c);
    trace_idx = 3'd7; #1;
    chk("trace_idx7", trace_pc, 32'h8);
`else
    chk("trace_cnt_off", trace_cnt, 4'd0);
    chk("trace_pc_off", trace_pc, 32'h0);
`endif

    // Rotation wraps MSB into LSB.
    alures = 32'h8000_0000; pc = 32'h28;
    step();
    chk("sig_msb", signature, 32'h8000_0000);
    alures = 32'h0; pc = 32'h2c;
    step();
    chk("sig_wrap", signature, 32'h1);
    chk("cycles_11", cycles, 32'd11);

    // Breakpoint at 0x10, then resume.
    bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h10;
    step();
    chk("bp_state", state, 3'd4);
    chk("bp_stall", cpu_stall, 1'b1);
    chk("bp_cycles", cycles, 32'd12);
    pc = 32'h14; alures = 32'hFFFF;
    step();
    chk("bp_hold_state", state, 3'd4);
    chk("bp_frozen_cycles", cycles, 32'd12);
    chk("bp_frozen_sig", signature, 32'h2);
    resume = 1'b1; bp_en = 1'b0; alures = 32'h0;
    step();
    resume = 1'b0;
    chk("resume_state", state, 3'd1);
    chk("resume_stall", cpu_stall, 1'b0);
    chk("resume_cycles", cycles, 32'd12);

    // Halt and breakpoint on the same cycle: halt wins.
    bp_en = 1'b1; bp_addr = 32'h18; pc = 32'h18; halt = 1'b1;
    step();
    chk("halt_state", state, 3'd2);
    chk("halt_stall", cpu_stall, 1'b0);
    halt = 1'b0; bp_en = 1'b0;
    step();
    chk("halt_terminal", state, 3'd2);
    chk("halt_cycles", cycles, 32'd13);

    // Clear from HALTED restarts the hold sequence.
    clear = 1'b1;
    step();
    clear = 1'b0; pc = 32'h40;
    chk("clr_state", state, 3'd0);
    chk("clr_cpu_rst", cpu_rst, 1'b1);
    chk("clr_cycles", cycles, 32'd0);
    chk("clr_sig", signature, 32'd0);
    step();
    chk("clr_hold", state, 3'd0);
    step();
    chk("clr_run", state, 3'd1);

    // Watchdog: PC stuck at 0x40.
    alures = 32'h5;
    step();
    chk("wd_sig5", signature, 32'h5);
    alures = 32'h0;
    repeat (14) step();
    chk("wd_pre_state", state, 3'd1);
    chk("wd_pre_cycles", cycles, 32'd15);
    step();
    chk("wd_state", state, 3'd3);
    chk("wd_cycles", cycles, 32'd16);
    chk("wd_sig", signature, 32'h0002_8000);
    repeat (2) step();
    chk("wd_terminal", state, 3'd3);
    chk("wd_frozen", cycles, 32'd16);
    chk("wd_tcnt", trace_cnt, 4'd0);

    // Clear in TIMEOUT.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clrto_state", state, 3'd0);
    chk("clrto_cycles", cycles, 32'd0);
    chk("clrto_sig", signature, 32'd0);
    chk("clrto_tcnt", trace_cnt, 4'd0);

    // PC change rearms the watchdog.
    repeat (2) step();
    repeat (10) step();
    pc = 32'h44;
    step();
    repeat (15) step();
    chk("wdre_state", state, 3'd1);
    chk("wdre_cycles", cycles, 32'd26);
`ifdef RUN_MON_TRACE_EN
    chk("wdre_tcnt", trace_cnt, 4'd1);
    trace_idx = 3'd0; #1;
    chk("wdre_idx0", trace_pc, 32'h44);
    trace_idx = 3'd1; #1;
    chk("wdre_idx1_empty", trace_pc, 32'h0);
`else
    chk("wdre_tcnt_off", trace_cnt, 4'd0);
`endif
    step();
    chk("wdre_to", state, 3'd3);
    chk("wdre_to_cycles", cycles, 32'd27);

    // Asynchronous reset mid-RUN.
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (2) step();
    alures = 32'h3;
    repeat (3) step();
    chk("ar_pre_cycles", cycles, 32'd3);
    chk("ar_pre_sig", signature, 32'h9);
    #2 rst = 1'b0;
    #1;
    chk("ar_state", state, 3'd0);
    chk("ar_cpu_rst", cpu_rst, 1'b1);
    chk("ar_cycles", cycles, 32'd0);
    chk("ar_sig", signature, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("ar_hold", state, 3'd0);
    step();
    chk("ar_run", state, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
